diffusion_engine: RTL
=====================

# diffusion_engine

- Sequential, parametrised successor to the combinational AES diffusion layer.
- Performs the full round diffusion on one 4×4 byte state per transaction, in either of two modes:
  - forward: ShiftRows then MixColumns;
  - inverse: InvMixColumns then InvShiftRows.
- Processes COLS_PER_CYCLE columns per clock behind a valid/ready handshake.
- Sits between the substitution stage and round-key addition in the iterative cipher datapath.

## Interface
- COLS_PER_CYCLE, 1 — columns mixed per clock; legal values 1, 2, 4. Define N = 4/COLS_PER_CYCLE.
- clk  in  1  — the single clock.
- rst  in  1  — reset; synchronous, active-high.
- in_valid  in  1  — input block offered.
- in_ready  out  1  — engine can accept a block.
- mode  in  1  — mode select, sampled on accept: 0 = forward, 1 = inverse.
- data_in  in  [7:0] ×[3:0][3:0]  — state, indexed [row][column]; column 3 is the first (leftmost) column.
- out_valid  out  1  — result available.
- out_ready  in  1  — downstream accepts the result.
- data_out  out  [7:0] ×[3:0][3:0]  — result, same indexing as data_in.
- skip_mix  in  1  — present only with DIFFUSION_SKIPMIX_EN; sampled on accept.

## Operation
- **Column bus.** Each column is packed as {row3, row2, row1, row0}.
- **Forward ShiftRows:** out[r][c] = in[r][(c−r) mod 4].
- **InvShiftRows:** out[r][c] = in[r][(c+r) mod 4].
- **MixColumns:** standard GF(2^8) arithmetic, polynomial 0x11B. Forward matrix {02,03,01,01}; inverse matrix {0E,0B,0D,09}.
- **FSM states: IDLE, MIX, DONE.**
  - IDLE: in_ready=1. On in_valid, register mode. In forward mode register ShiftRows(data_in); in inverse mode register data_in raw. Clear the column counter, then go to MIX.
  - MIX: each cycle, replace COLS_PER_CYCLE columns of the state register with their (inverse) mix, in the order column 3 first, down to column 0. Counter width is 2 bits; increment by COLS_PER_CYCLE. After N cycles go to DONE.
  - DONE: out_valid=1.
    - data_out = register (forward), or InvShiftRows(register) (inverse), applied combinationally.
    - Hold both until out_ready.
    - On out_ready: go to IDLE, or, if in_valid is also high, accept the new block and go straight to MIX.
- **in_ready** = (IDLE) or (DONE and out_ready).
- **Input stability.** data_in and mode are ignored outside the accept cycle. A block in flight is unaffected by input changes.
- **Reset.** rst has priority over all events. Next cycle: FSM=IDLE, out_valid=0, in_ready=1, state register = 0, so data_out=0. An in-flight block is discarded and never emitted.

## Timing
- Accept edge T → out_valid high from edge T+N+1.
  - Latency is N+1 cycles: 5 for COLS_PER_CYCLE=1, 3 for 2, 2 for 4.
- Sustained throughput with out_ready held high is one block per N+1 cycles, back-to-back through DONE.
- out_valid and data_out change only on clk edges. No combinational path from in_valid to out_valid.
- There is a combinational path from out_ready to in_ready (DONE only).

## Configuration
- **DIFFUSION_SKIPMIX_EN defined:** the skip_mix port exists.
  - With skip_mix=1 on accept, the MIX state is skipped and the FSM goes IDLE→DONE.
  - Result is ShiftRows only (forward) or InvShiftRows only (inverse); latency is 1 cycle.
  - Used for the AES final round.
- **Not defined:** no port; every block passes through MIX.

## Structure
- **Package diffusion_pkg:**
  - state typedef ([7:0] [3:0][3:0]);
  - FSM enum;
  - mode constants MODE_FWD/MODE_INV;
  - GF helper functions xtime, gmul2/3/9/11/13/14;
  - shift_rows/inv_shift_rows functions.
- **Sub-module mix_col_unit:** 32-bit column in/out plus mode. Purely combinational; instantiated COLS_PER_CYCLE times, muxed by the column counter.

## Test plan
- **Forward mix:**
  - Stimulus: COLS_PER_CYCLE=1, mode=0; rows constant: row0=db, row1=13, row2=53, row3=45 in every column.
  - Required: ShiftRows is a no-op, and out_valid rises 5 cycles after accept with every column = {row0 8e, row1 4d, row2 a1, row3 bc}.
- **Inverse mix:**
  - Stimulus: COLS_PER_CYCLE=4, mode=1; rows 8e/4d/a1/bc.
  - Required: rows db/13/53/45, latency 2 cycles.
- **Round trip:**
  - Stimulus: 100 random states, forward result fed back in inverse mode, at each legal COLS_PER_CYCLE.
  - Required: output equals the original state.
- **Backpressure:**
  - Stimulus: out_ready low for 3 cycles in DONE.
  - Required: out_valid and data_out stable, in_ready=0.
  - Then: raise out_ready with in_valid=1 in the same cycle. Required: second block accepted that edge; its result appears N+1 cycles later.
- **Reset mid-MIX:**
  - Stimulus: rst pulsed in the second MIX cycle.
  - Required: next cycle out_valid=0, in_ready=1, data_out=0; the aborted block never appears.
- **Skip-mix (DIFFUSION_SKIPMIX_EN):**
  - Stimulus: mode=0, skip_mix=1, row1 (col3..col0) = 00 01 02 03.
  - Required: after 1 cycle, row1 = 01 02 03 00; rows 0, 2, 3 shifted by 0, 2, 3 respectively.

Source files
------------

// File: rtl/diffusion_pkg.sv
// Shared types and GF(2^8) helpers for the AES diffusion engine.
// The state is indexed [row][column]; column 3 is the leftmost column.
package diffusion_pkg;

  typedef logic [3:0][3:0][7:0] state_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MIX,
    ST_DONE
  } fsm_e;

  localparam logic MODE_FWD = 1'b0;
  localparam logic MODE_INV = 1'b1;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul2(input logic [7:0] b);
    return xtime(b);
  endfunction

  function automatic logic [7:0] gmul3(input logic [7:0] b);
    return xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] gmul9(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ b;
  endfunction

  function automatic logic [7:0] gmul11(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] gmul13(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
  endfunction

  function automatic logic [7:0] gmul14(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
  endfunction

  // Row r rotates so that out[r][c] = in[r][(c-r) mod 4]
  function automatic state_t shift_rows(input state_t s);
    state_t o;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        o[r][c] = s[r][2'(c - r)];
      end
    end
    return o;
  endfunction

  function automatic state_t inv_shift_rows(input state_t s);
    state_t o;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        o[r][c] = s[r][2'(c + r)];
      end
    end
    return o;
  endfunction

endpackage

// File: rtl/mix_col_unit.sv
// Combinational (Inv)MixColumns on one column packed as {row3, row2, row1, row0}.
module mix_col_unit
  import diffusion_pkg::*;
(
  input  logic        i_mode,
  input  logic [31:0] i_col,
  output logic [31:0] o_col
);

  logic [7:0] w_a   [4];
  logic [7:0] w_fwd [4];
  logic [7:0] w_inv [4];

  for (genvar gi = 0; gi < 4; gi++) begin : g_row
    // Circulant matrix: row gi uses the coefficients rotated by gi
    localparam int R1 = (gi + 1) % 4;
    localparam int R2 = (gi + 2) % 4;
    localparam int R3 = (gi + 3) % 4;

    assign w_a[gi]   = i_col[8*gi +: 8];
    assign w_fwd[gi] = gmul2(w_a[gi]) ^ gmul3(w_a[R1]) ^ w_a[R2] ^ w_a[R3];
    assign w_inv[gi] = gmul14(w_a[gi]) ^ gmul11(w_a[R1]) ^ gmul13(w_a[R2]) ^ gmul9(w_a[R3]);
    assign o_col[8*gi +: 8] = (i_mode == MODE_INV) ? w_inv[gi] : w_fwd[gi];
  end

endmodule

// File: rtl/diffusion_engine.sv
// Sequential AES diffusion layer: ShiftRows+MixColumns or InvMixColumns+InvShiftRows,
// COLS_PER_CYCLE columns per clock. Optional macro DIFFUSION_SKIPMIX_EN adds skip_mix.
module diffusion_engine
  import diffusion_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   in_valid,
  output logic   in_ready,
  input  logic   mode,
  input  state_t data_in,
  output logic   out_valid,
  input  logic   out_ready,
  output state_t data_out
`ifdef DIFFUSION_SKIPMIX_EN
  ,
  input  logic   skip_mix
`endif
);

  localparam logic [1:0] LAST_CNT = 2'(4 - COLS_PER_CYCLE);
  localparam logic [1:0] CNT_STEP = 2'(COLS_PER_CYCLE);

  fsm_e       r_fsm;
  state_t     r_state;
  logic       r_mode;
  logic [1:0] r_cnt;
  logic       r_out_valid;

  logic       w_skip;
  logic       w_accept;
  state_t     w_load_state;
  fsm_e       w_load_fsm;
  state_t     w_state_mixed;
  logic [1:0] w_col_idx [COLS_PER_CYCLE];
  logic [31:0] w_col_in  [COLS_PER_CYCLE];
  logic [31:0] w_col_out [COLS_PER_CYCLE];

`ifdef DIFFUSION_SKIPMIX_EN
  assign w_skip = skip_mix;
`else
  assign w_skip = 1'b0;
`endif

  // The DONE state spends one cycle presenting the result before out_valid rises
  assign in_ready  = (r_fsm == ST_IDLE) || ((r_fsm == ST_DONE) && r_out_valid && out_ready);
  assign w_accept  = in_valid && in_ready;
  assign out_valid = r_out_valid;
  assign data_out  = (r_mode == MODE_INV) ? inv_shift_rows(r_state) : r_state;

  assign w_load_state = (mode == MODE_FWD) ? shift_rows(data_in) : data_in;
  assign w_load_fsm   = w_skip ? ST_DONE : ST_MIX;

  for (genvar gi = 0; gi < COLS_PER_CYCLE; gi++) begin : g_col
    assign w_col_idx[gi] = 2'd3 - r_cnt - 2'(gi);
    assign w_col_in[gi]  = {r_state[3][w_col_idx[gi]], r_state[2][w_col_idx[gi]],
                            r_state[1][w_col_idx[gi]], r_state[0][w_col_idx[gi]]};

    mix_col_unit u_mix (
      .i_mode (r_mode),
      .i_col  (w_col_in[gi]),
      .o_col  (w_col_out[gi])
    );
  end

  always_comb begin
    w_state_mixed = r_state;
    for (int j = 0; j < COLS_PER_CYCLE; j++) begin
      for (int r = 0; r < 4; r++) begin
        w_state_mixed[r][w_col_idx[j]] = w_col_out[j][8*r +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fsm       <= ST_IDLE;
      r_state     <= '0;
      r_mode      <= MODE_FWD;
      r_cnt       <= 2'd0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_fsm)
        ST_IDLE: begin
          if (w_accept) begin
            r_state <= w_load_state;
            r_mode  <= mode;
            r_cnt   <= 2'd0;
            r_fsm   <= w_load_fsm;
          end
        end
        ST_MIX: begin
          r_state <= w_state_mixed;
          r_cnt   <= r_cnt + CNT_STEP;
          if (r_cnt == LAST_CNT) begin
            r_fsm <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
            if (in_valid) begin
              r_state <= w_load_state;
              r_mode  <= mode;
              r_cnt   <= 2'd0;
              r_fsm   <= w_load_fsm;
            end else begin
              r_fsm <= ST_IDLE;
            end
          end
        end
        default: r_fsm <= ST_IDLE;
      endcase
    end
  end

endmodule
